// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: show-ahead FIFO read adapter with a 2-entry registered skid buffer and a valid/ready output
module fifo_rd_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_fifo_rdata,
  input  logic             i_fifo_not_empty,
  output logic             o_fifo_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_level,
  output logic [CNT_W-1:0] o_beat_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] slot0, slot1, slot0_nx, slot1_nx;
  logic [CNT_W-1:0] cnt;
  logic p, c;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      slot0 <= slot0_nx;
      slot1 <= slot1_nx;
      cnt   <= cnt + CNT_W'(c);
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = p ? ONE : EMPTY;
      ONE:     state_nx = (p && !c) ? TWO : (!p && c) ? EMPTY : ONE;
      TWO:     state_nx = c ? ONE : TWO;
      default: state_nx = EMPTY;
    endcase
    // pop is never asserted in TWO, so a pop here always lands in slot0 or slot1
    slot0_nx = (p && (state == EMPTY || c)) ? i_fifo_rdata : (state == TWO && c) ? slot1 : slot0;
    slot1_nx = (state == ONE && p && !c) ? i_fifo_rdata : slot1;
  end
  always_comb begin
    o_valid    = state != EMPTY;
    o_level    = state;
    o_fifo_pop = i_fifo_not_empty && !i_flush && !i_rst && state != TWO;
    o_data     = slot0;
    o_beat_cnt = cnt;
    p          = o_fifo_pop;
    c          = o_valid && i_ready;
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: queue-based reference model, vector table and directed corner sequences
module tb_fifo_rd_stream;
  localparam int W = 16;
  localparam int CW = 4;
  logic          i_clk = 1'b0;
  logic          i_rst, i_flush, i_fifo_not_empty, i_ready;
  logic [W-1:0]  i_fifo_rdata;
  logic          o_fifo_pop, o_valid;
  logic [W-1:0]  o_data;
  logic [1:0]    o_level;
  logic [CW-1:0] o_beat_cnt;

  fifo_rd_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_fifo_rdata(i_fifo_rdata), .i_fifo_not_empty(i_fifo_not_empty),
    .o_fifo_pop(o_fifo_pop), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .o_level(o_level), .o_beat_cnt(o_beat_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit         rst, flush, rdy;
    logic [1:0] lvl;
    bit         pop;
    logic [15:0] data;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl[15];

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] buf_q[$];
  logic [W-1:0] out_q[$];
  logic [W-1:0] m_data;
  int m_cnt, pops;
  bit cur_r, cur_f, cur_rd, cur_p;
  int n_checks = 0, n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input bit r, input bit f, input bit rd, input bit av);
    i_rst = r; i_flush = f; i_ready = rd;
    i_fifo_not_empty = av && fifo_q.size() > 0;
    i_fifo_rdata = fifo_q.size() > 0 ? fifo_q[0] : 16'hdead;
    cur_r = r; cur_f = f; cur_rd = rd;
    cur_p = i_fifo_not_empty && !f && !r && buf_q.size() < 2;
    #1;
    chk("model_valid", {31'd0, o_valid}, {31'd0, buf_q.size() != 0});
    chk("model_level", {30'd0, o_level}, buf_q.size());
    chk("model_data", {16'd0, o_data}, {16'd0, m_data});
    chk("model_pop", {31'd0, o_fifo_pop}, {31'd0, cur_p});
    chk("model_cnt", {28'd0, o_beat_cnt}, m_cnt);
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (cur_r || cur_f) begin
      buf_q.delete();
      m_data = '0;
      m_cnt = 0;
    end else begin
      if (buf_q.size() > 0 && cur_rd) begin
        out_q.push_back(buf_q.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (cur_p) begin
        buf_q.push_back(fifo_q.pop_front());
        pops++;
      end
      if (buf_q.size() > 0) m_data = buf_q[0];
    end
    @(negedge i_clk);
  endtask

  task automatic step(input bit r, input bit f, input bit rd, input bit av);
    apply(r, f, rd, av);
    tick();
  endtask

  task automatic restart(input int n);
    fifo_q.delete();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    out_q.delete();
    pops = 0;
    for (int i = 1; i <= n; i++) fifo_q.push_back(W'(i));
  endtask

  task automatic chk_order(input string nm, input int n);
    chk({nm, "_len"}, out_q.size(), n);
    for (int i = 0; i < n && i < out_q.size(); i++) chk(nm, {16'd0, out_q[i]}, i + 1);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 2'd0, 1, 16'h0, 4'd0};
    tbl[1]  = '{0, 0, 0, 2'd1, 1, 16'h1, 4'd0};
    tbl[2]  = '{0, 0, 0, 2'd2, 0, 16'h1, 4'd0};
    tbl[3]  = '{0, 0, 0, 2'd2, 0, 16'h1, 4'd0};
    tbl[4]  = '{0, 0, 1, 2'd2, 0, 16'h1, 4'd0};
    tbl[5]  = '{0, 0, 1, 2'd1, 1, 16'h2, 4'd1};
    tbl[6]  = '{0, 0, 1, 2'd1, 1, 16'h3, 4'd2};
    tbl[7]  = '{0, 0, 0, 2'd1, 1, 16'h4, 4'd3};
    tbl[8]  = '{0, 0, 0, 2'd2, 0, 16'h4, 4'd3};
    tbl[9]  = '{0, 0, 1, 2'd2, 0, 16'h4, 4'd3};
    tbl[10] = '{0, 0, 1, 2'd1, 1, 16'h5, 4'd4};
    tbl[11] = '{0, 0, 1, 2'd1, 1, 16'h6, 4'd5};
    tbl[12] = '{0, 0, 1, 2'd1, 1, 16'h7, 4'd6};
    tbl[13] = '{0, 0, 1, 2'd1, 0, 16'h8, 4'd7};
    tbl[14] = '{0, 0, 1, 2'd0, 0, 16'h8, 4'd8};
    m_data = '0; m_cnt = 0; pops = 0;
    i_rst = 1'b1; i_flush = 1'b0; i_ready = 1'b0; i_fifo_not_empty = 1'b0; i_fifo_rdata = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);

    apply(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_level", {30'd0, o_level}, 0);
    chk("rst_data", {16'd0, o_data}, 0);
    chk("rst_cnt", {28'd0, o_beat_cnt}, 0);
    chk("rst_pop", {31'd0, o_fifo_pop}, 0);
    tick();

    restart(8);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("stream_pops", pops, 8);
    chk("stream_cnt", {28'd0, o_beat_cnt}, 8);
    chk("stream_level", {30'd0, o_level}, 0);
    chk("stream_hold_data", {16'd0, o_data}, 16'h8);
    chk_order("stream_order", 8);

    restart(8);
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].rst, tbl[i].flush, tbl[i].rdy, 1'b1);
      chk("tbl_level", {30'd0, o_level}, {30'd0, tbl[i].lvl});
      chk("tbl_valid", {31'd0, o_valid}, {31'd0, tbl[i].lvl != 0});
      chk("tbl_pop", {31'd0, o_fifo_pop}, {31'd0, tbl[i].pop});
      chk("tbl_data", {16'd0, o_data}, {16'd0, tbl[i].data});
      chk("tbl_cnt", {28'd0, o_beat_cnt}, {28'd0, tbl[i].cnt});
      tick();
    end
    chk_order("bp_order", 8);

    restart(8);
    for (int k = 0; k < 24; k++) step(1'b0, 1'b0, 1'b1, k % 2 == 0);
    chk("bubble_pops", pops, 8);
    chk_order("bubble_order", 8);

    restart(8);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_pre_level", {30'd0, o_level}, 2);
    apply(1'b0, 1'b1, 1'b1, 1'b1);
    chk("flush_pop", {31'd0, o_fifo_pop}, 0);
    tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_level", {30'd0, o_level}, 0);
    chk("flush_valid", {31'd0, o_valid}, 0);
    chk("flush_cnt", {28'd0, o_beat_cnt}, 0);
    chk("flush_data", {16'd0, o_data}, 0);
    tick();
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_resume_pop", {31'd0, o_fifo_pop}, 1);
    tick();

    restart(17);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("wrap_cnt", {28'd0, o_beat_cnt}, 1);

    restart(0);
    for (int k = 0; k < 3000; k++) begin
      if (fifo_q.size() < 5 && $urandom_range(0, 1) == 1) fifo_q.push_back(W'($urandom));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
